// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential nibble-serial add/subtract unit.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    // Minimum bit count able to index 'value' distinct items (at least 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_seq_adder_nibble_add.sv
// Combinational NIBBLE_W-bit ripple-carry adder used one nibble per cycle by alu_seq_adder.
module nibble_add
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic carry_s;

    // Explicit bit-by-bit ripple so the carry chain is visible in the netlist.
    always_comb begin
        sum     = {NIBBLE_W{1'b0}};
        carry_s = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ carry_s;
            carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
        end
        cout = carry_s;
    end

endmodule

// File: rtl/alu_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract, one nibble per cycle LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining ALU_SEQ_ADDER_OVF_EN.
module alu_seq_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
`ifdef ALU_SEQ_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_zero
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int CNT_W = clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    add_state_t         state_r;
    add_state_t         state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_res_r;
    logic               out_cout_r;
    logic               out_zero_r;

    logic [NIBBLE_W-1:0] nib_sum_s;
    logic                nib_cout_s;
    logic [WIDTH-1:0]    res_next_s;
    logic                accept_s;
    logic                step_s;
    logic                last_s;
    logic                release_s;

    nibble_add u_nibble_add (
        .a    (a_r[NIBBLE_W-1:0]),
        .b    (b_r[NIBBLE_W-1:0]),
        .cin  (carry_r),
        .sum  (nib_sum_s),
        .cout (nib_cout_s)
    );

    // Operands shift right each cycle, so the active nibble is always bits [3:0].
    assign res_next_s = {nib_sum_s, res_r[WIDTH-1:NIBBLE_W]};
    assign accept_s   = (state_r == IDLE) && in_valid;
    assign step_s     = (state_r == RUN);
    assign last_s     = step_s && (cnt_r == CNT_LAST);
    assign release_s  = (state_r == DONE) && out_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (release_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture and nibble-serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_r     <= in_a;
            b_r     <= in_b ^ {WIDTH{in_sub}};
            carry_r <= in_sub ? 1'b1 : in_cin;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (step_s) begin
            a_r     <= a_r >> NIBBLE_W;
            b_r     <= b_r >> NIBBLE_W;
            res_r   <= res_next_s;
            carry_r <= nib_cout_s;
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Handshake outputs track the next state so they are registered, not decoded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Result and flags are loaded once on the final nibble and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_res_r  <= {WIDTH{1'b0}};
            out_cout_r <= 1'b0;
            out_zero_r <= 1'b0;
        end else if (last_s) begin
            out_res_r  <= res_next_s;
            out_cout_r <= nib_cout_s;
            out_zero_r <= (res_next_s == {WIDTH{1'b0}});
        end
    end

`ifdef ALU_SEQ_ADDER_OVF_EN
    logic out_ovf_r;

    // Signed overflow: same-sign operands yielding a result of the other sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_r <= 1'b0;
        end else if (last_s) begin
            out_ovf_r <= (a_r[NIBBLE_W-1] == b_r[NIBBLE_W-1]) &&
                         (nib_sum_s[NIBBLE_W-1] != a_r[NIBBLE_W-1]);
        end
    end

    assign out_ovf = out_ovf_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_res   = out_res_r;
    assign out_cout  = out_cout_r;
    assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_alu_seq_adder.sv
// Directed self-checking bench for alu_seq_adder (WIDTH=16, four nibble cycles per op).
module tb_alu_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic        out_cout;
    logic        out_zero;
`ifdef ALU_SEQ_ADDER_OVF_EN
    logic        out_ovf;
`endif

    int total;
    int bad;

    alu_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_cout  (out_cout),
`ifdef ALU_SEQ_ADDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op from IDLE, check latency, results, then hand the result off.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin,
                          input logic [15:0] er, input logic ec, input logic ez);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"},   {16'd0, out_res},   {16'd0, er});
        check({tag, "_cout"},  {31'd0, out_cout},  {31'd0, ec});
        check({tag, "_zero"},  {31'd0, out_zero},  {31'd0, ez});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000;
        in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready},  32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res",   {16'd0, out_res},   32'd0);
        check("rst_flags", {30'd0, out_cout, out_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("t1_add",    16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0);
`ifdef ALU_SEQ_ADDER_OVF_EN
        check("t1_ovf", {31'd0, out_ovf}, 32'd0);
`endif
        run_op("t2_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef ALU_SEQ_ADDER_OVF_EN
        check("t2_ovf", {31'd0, out_ovf}, 32'd0);
`endif
        run_op("t3_sub",    16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
`ifdef ALU_SEQ_ADDER_OVF_EN
        check("t3_ovf", {31'd0, out_ovf}, 32'd0);
`endif
        run_op("t4_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0);
`ifdef ALU_SEQ_ADDER_OVF_EN
        check("t4_ovf", {31'd0, out_ovf}, 32'd1);
`endif
        run_op("t_cin",     16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        run_op("t_subcin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("t_subeq",   16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("t_subneg",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b0);
`ifdef ALU_SEQ_ADDER_OVF_EN
        check("t_subneg_ovf", {31'd0, out_ovf}, 32'd1);
`endif

        // Backpressure: hold out_ready low in DONE while a new request waits.
        in_a = 16'hAAAA; in_b = 16'h1111; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 16'h0001; in_b = 16'h0001;
        repeat (4) @(posedge clk);
        #1;
        check("t5_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t5_hold_res",   {16'd0, out_res},   32'h0000BBBB);
            check("t5_hold_ready", {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_handoff", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t5_accepted", {31'd0, in_ready}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_next_valid", {31'd0, out_valid}, 32'd1);
        check("t5_next_res",   {16'd0, out_res},   32'h00000002);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of an operation.
        in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_ready", {31'd0, in_ready},  32'd1);
        check("t6_rst_res",   {16'd0, out_res},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t6_after", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
